// File: rtl/mem_arbiter_if.sv
// Pipe-side fetch/data ports and unified-memory port of the shared memory arbiter.
// The arbiter takes the slave view; the pipe and memory together form the master side.
interface mem_arbiter_if;
  logic        inst_mem_is_ready;
  logic [31:0] inst_mem_address;
  logic [31:0] inst_mem_read_data;
  logic        inst_mem_is_valid;
  logic        dmem_read_ready;
  logic [31:0] dmem_read_address;
  logic        dmem_write_ready;
  logic [31:0] dmem_write_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_byte;
  logic [31:0] dmem_read_data_temp;
  logic        dmem_read_valid;
  logic        dmem_write_valid;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic [29:0] mem_read_address;
  logic [29:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;
  logic [31:0] mem_read_data;
  logic        addr_err;

  modport slave (
    input  inst_mem_is_ready, inst_mem_address,
    input  dmem_read_ready, dmem_read_address,
    input  dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
    input  mem_read_data,
    output inst_mem_read_data, inst_mem_is_valid,
    output dmem_read_data_temp, dmem_read_valid, dmem_write_valid,
    output mem_read_ready, mem_write_ready, mem_read_address, mem_write_address,
    output mem_write_data, mem_write_byte, addr_err
  );

  modport master (
    output inst_mem_is_ready, inst_mem_address,
    output dmem_read_ready, dmem_read_address,
    output dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
    output mem_read_data,
    input  inst_mem_read_data, inst_mem_is_valid,
    input  dmem_read_data_temp, dmem_read_valid, dmem_write_valid,
    input  mem_read_ready, mem_write_ready, mem_read_address, mem_write_address,
    input  mem_write_data, mem_write_byte, addr_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between instruction fetch and data
// access; each access is one grant cycle followed by one response cycle.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GNT_I  = 3'd1;
  localparam logic [2:0] S_GNT_DR = 3'd2;
  localparam logic [2:0] S_GNT_DW = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] K_I  = 2'd0;
  localparam logic [1:0] K_DR = 2'd1;
  localparam logic [1:0] K_DW = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic              last_d_q, last_d_d;   // 1: data side won the most recent grant
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wbyte_q, wbyte_d;
  logic              err_q, err_d;

  logic d_req;
  logic pick_i;

  assign d_req  = bus.dmem_write_ready | bus.dmem_read_ready;
  assign pick_i = bus.inst_mem_is_ready & (~d_req | last_d_q);

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbyte_d  = wbyte_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (pick_i) begin
          state_d  = S_GNT_I;
          kind_d   = K_I;
          last_d_d = 1'b0;
          addr_d   = bus.inst_mem_address;
        end else if (bus.dmem_write_ready) begin
          state_d  = S_GNT_DW;
          kind_d   = K_DW;
          last_d_d = 1'b1;
          addr_d   = bus.dmem_write_address;
          wdata_d  = bus.dmem_write_data;
          wbyte_d  = bus.dmem_write_byte;
        end else if (bus.dmem_read_ready) begin
          state_d  = S_GNT_DR;
          kind_d   = K_DR;
          last_d_d = 1'b1;
          addr_d   = bus.dmem_read_address;
        end
      end
      S_GNT_I, S_GNT_DR, S_GNT_DW: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Range is judged once on the latched address and carried through the response.
  assign err_d = |addr_d[31:ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_I;
      last_d_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbyte_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbyte_q  <= wbyte_d;
      if (state_d != state_q && (state_d == S_GNT_I || state_d == S_GNT_DR ||
                                 state_d == S_GNT_DW)) begin
        err_q <= err_d;
      end
    end
  end

  logic [29:0] word_addr;
  logic        rd_strobe, wr_strobe, resp;

  assign word_addr = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W-1:2]};
  assign rd_strobe = (state_q == S_GNT_I || state_q == S_GNT_DR) & ~err_q;
  assign wr_strobe = (state_q == S_GNT_DW) & ~err_q;
  assign resp      = (state_q == S_RESP);

  assign bus.mem_read_ready    = rd_strobe;
  assign bus.mem_read_address  = rd_strobe ? word_addr : 30'd0;
  assign bus.mem_write_ready   = wr_strobe;
  assign bus.mem_write_address = wr_strobe ? word_addr : 30'd0;
  assign bus.mem_write_data    = wr_strobe ? wdata_q : 32'd0;
  assign bus.mem_write_byte    = wr_strobe ? wbyte_q : 4'd0;

  assign bus.inst_mem_is_valid   = resp & (kind_q == K_I);
  assign bus.dmem_read_valid     = resp & (kind_q == K_DR);
  assign bus.dmem_write_valid    = resp & (kind_q == K_DW);
  assign bus.addr_err            = resp & err_q;
  assign bus.inst_mem_read_data  = (bus.inst_mem_is_valid & ~err_q) ? bus.mem_read_data : 32'd0;
  assign bus.dmem_read_data_temp = (bus.dmem_read_valid & ~err_q) ? bus.mem_read_data : 32'd0;
endmodule
